// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: ID-stage hazard request and hazard-control response bundle.
//
// Handshake: id_valid qualifies every id_* field in the same cycle. stall is the
// back-pressure: while stall is high the producer must hold the ID contents
// unchanged (ifIdWrIn = ~stall), and the instruction is taken into EX on the
// first rising edge where stall is low. With id_valid low nothing is requested
// and stall stays low.
//
// dbg_ex/dbg_mem/dbg_wb expose the shadow stage records as
// {valid, rw[4:0], regwr, load} for observation.
interface pipeline_hazard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rw;
  logic        id_regwr;
  logic        id_load;
  logic        id_store;
  logic        id_branch;

  logic        stall;
  logic        ifIdWrIn;
  logic        bubble;
  logic [3:0]  fwd_ex;
  logic [1:0]  fwd_id;
  logic        mem_wb_mem;
  logic [15:0] stall_count;

  logic [7:0]  dbg_ex;
  logic [7:0]  dbg_mem;
  logic [7:0]  dbg_wb;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output id_rw, id_regwr, id_load, id_store, id_branch,
    input  stall, ifIdWrIn, bubble, fwd_ex, fwd_id, mem_wb_mem, stall_count,
    input  dbg_ex, dbg_mem, dbg_wb
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  id_rw, id_regwr, id_load, id_store, id_branch,
    output stall, ifIdWrIn, bubble, fwd_ex, fwd_id, mem_wb_mem, stall_count,
    output dbg_ex, dbg_mem, dbg_wb
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall / bubble / forwarding control for a 5-stage pipeline.
// Keeps shadow records of the EX, MEM and WB stages and compares them against
// the instruction sitting in ID. All control outputs are combinational; only
// the shadow records and the saturating stall counter are registered.
//
// Optional feature macro: HAZ_STORE_FWD_EN
//   defined   - a store whose rs2 (data) comes from an EX-stage load does not
//               stall; mem_wb_mem routes the load result into the store at MEM.
//   undefined - mem_wb_mem is tied 0 and that case is an ordinary load-use stall.
module pipeline_hazard_ctrl (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rw;
    logic       regwr;
    logic       load;
  } stage_t;

  stage_t      ex_q, ex_d;
  stage_t      mem_q, mem_d;
  stage_t      wb_q, wb_d;
  logic [15:0] cnt_q, cnt_d;

  logic        rs1_ex, rs2_ex, rs1_mem, rs2_mem;
  logic        lu_rs1, lu_rs2;
  logic        store_fwd;
  logic        lu_stall, br_stall, stall_w;
  logic [3:0]  fwd_ex_w;
  logic [1:0]  fwd_id_w;
  logic        mwm_w;

  // A stage produces r when it holds a real register-writing instruction whose
  // destination is r; r0 is hard-wired zero and never produced.
  function automatic logic produces(input stage_t s, input logic [4:0] r);
    return s.valid && s.regwr && (s.rw == r) && (r != 5'd0);
  endfunction

  // Source matching, stall decision and forwarding selects for the ID instruction.
  always_comb begin
    rs1_ex   = hz.id_valid && hz.id_use_rs1 && produces(ex_q,  hz.id_rs1);
    rs2_ex   = hz.id_valid && hz.id_use_rs2 && produces(ex_q,  hz.id_rs2);
    rs1_mem  = hz.id_valid && hz.id_use_rs1 && produces(mem_q, hz.id_rs1);
    rs2_mem  = hz.id_valid && hz.id_use_rs2 && produces(mem_q, hz.id_rs2);

    lu_rs1   = rs1_ex && ex_q.load;
    lu_rs2   = rs2_ex && ex_q.load;

`ifdef HAZ_STORE_FWD_EN
    // Store data can wait until MEM, where the load result is already in MEM/WB.
    store_fwd = hz.id_store && lu_rs2 && !lu_rs1;
`else
    store_fwd = hz.id_store & 1'b0;
`endif

    lu_stall = (lu_rs1 || lu_rs2) && !store_fwd;
    // Branches compare rs1 in ID, so any EX producer or a MEM load is too late.
    br_stall = hz.id_valid && hz.id_branch && (rs1_ex || (rs1_mem && mem_q.load));
    stall_w  = lu_stall || br_stall;

    fwd_ex_w = 4'b0000;
    fwd_id_w = 2'b00;
    mwm_w    = 1'b0;
    if (!stall_w) begin
      fwd_ex_w[0] = rs1_ex && !ex_q.load;
      fwd_ex_w[1] = rs2_ex && !ex_q.load;
      // Younger (EX) producer wins over the MEM producer.
      fwd_ex_w[2] = rs1_mem && !fwd_ex_w[0];
      fwd_ex_w[3] = rs2_mem && !fwd_ex_w[1];
      fwd_id_w[0] = hz.id_branch && rs1_mem && !mem_q.load;
      fwd_id_w[1] = hz.id_branch && rs2_mem && !mem_q.load;
      mwm_w       = store_fwd;
    end
  end

  // Next-state for the shadow pipeline and the saturating stall counter.
  always_comb begin
    ex_d = '0;
    if (!stall_w) begin
      ex_d.valid = hz.id_valid;
      ex_d.rw    = hz.id_rw;
      ex_d.regwr = hz.id_regwr;
      ex_d.load  = hz.id_load;
    end
    mem_d = ex_q;
    wb_d  = mem_q;
    cnt_d = cnt_q;
    // Counts the stall level actually presented on the output.
    if (hz.stall && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= 16'd0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign hz.stall       = stall_w;
  assign hz.ifIdWrIn    = ~stall_w;
  assign hz.bubble      = stall_w;
  assign hz.fwd_ex      = fwd_ex_w;
  assign hz.fwd_id      = fwd_id_w;
  assign hz.mem_wb_mem  = mwm_w;
  assign hz.stall_count = cnt_q;
  assign hz.dbg_ex      = ex_q;
  assign hz.dbg_mem     = mem_q;
  assign hz.dbg_wb      = wb_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The module SHALL have the following ports, all synchronous to clk:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction (0 for a branch-squashed or zero instruction).
- id_rs1, id_rs2  in  5 each  ID source register numbers.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads that source.
- id_rw  in  5  ID destination (after regDst/link muxing).
- id_regwr  in  1  ID instruction writes the register file.
- id_load, id_store, id_branch  in  1 each  ID instruction class; a branch compares rs1 in ID.
- stall  out  1  hold the PC and IF/ID this cycle.
- ifIdWrIn  out  1  IF/ID write enable; equals ~stall.
- bubble  out  1  zero the aluCtrl/exCtrl/memCtrl/wrCtrl fields entering ID/EX; equals stall.
- fwd_ex  out  4  [0]=exMemExA, [1]=exMemExB, [2]=memWbExA, [3]=memWbExB; ORed into exCtrl[6:3].
- fwd_id  out  2  [0]=exMemIdA, [1]=exMemIdB; drive idCtrl[2:1].
- mem_wb_mem  out  1  drives memCtrl[4] for a store.
- stall_count  out  16  saturating count of stall cycles.

Function
REQ-002 The module SHALL keep shadow records for the EX, MEM and WB stages: valid, rw[4:0], regwr, load.
- Every cycle EX<=ID, MEM<=EX, WB<=MEM.
- On a stall cycle EX SHALL load valid=0 (the bubble).
REQ-003 A stage "produces r" iff valid && regwr && rw==r && r!=0.
REQ-004 A source "matches" a stage iff the source's use bit is set and that stage produces the source register.
REQ-005 fwd_ex[0]/[1] SHALL assert when rs1/rs2 matches the EX record and that record is not a load.
REQ-006 fwd_ex[2]/[3] SHALL assert when rs1/rs2 matches the MEM record and fwd_ex[0]/[1] is not asserted. The younger producer wins.
REQ-007 Load-use: stall SHALL assert when rs1 or rs2 matches an EX-stage load, except the case in REQ-016.
REQ-008 If id_branch is set, stall SHALL also assert when:
- rs1 matches the EX record (any producer), or
- rs1 matches an MEM-stage load.
REQ-009 fwd_id[0] SHALL assert when id_branch is set, rs1 matches a non-load MEM record, and stall is low. fwd_id[1] SHALL follow the same rule for rs2.
REQ-010 WB-stage matches SHALL generate no forwarding and no stall; the register file writes on ~clk.
REQ-011 All outputs except stall_count SHALL be combinational from the current ID inputs and the shadow records (zero added latency). When id_valid=0, all outputs SHALL be 0, ifIdWrIn=1, and no stall.
REQ-012 Resulting stall lengths SHALL be:
- load-use: 1 cycle.
- branch on an EX-stage ALU producer: 1 cycle.
- branch on an EX-stage load: 2 cycles.
- branch on an MEM-stage load: 1 cycle.
REQ-013 While stall is high, fwd_ex, fwd_id and mem_wb_mem SHALL be 0, since the instruction is re-evaluated next cycle.
REQ-014 stall_count SHALL increment by 1 at each rising edge where stall=1, and SHALL saturate at 16'hFFFF without wrap.

Reset
REQ-015 With reset=0 at a rising edge:
- all shadow valid bits SHALL clear and stall_count SHALL become 0.
- in the following cycle, with id_valid=0, stall=0, bubble=0, ifIdWrIn=1, fwd_ex=0, fwd_id=0, mem_wb_mem=0.
- reset asserted mid-stall SHALL terminate the stall, with no residual stall after release.

Configuration
REQ-016 Macro HAZ_STORE_FWD_EN:
- Defined: when id_store is set and rs2 matches an EX-stage load (and rs1 does not), the module SHALL raise mem_wb_mem=1 with no stall.
- Undefined: mem_wb_mem SHALL be tied 0, and that case SHALL stall 1 cycle per REQ-007.

Verification
REQ-017 Scenario: add r3 in EX, then sub reading r3 (rs1) in ID -> fwd_ex=4'b0001, stall=0.
REQ-018 Scenario: lw r5 in EX, then add reading r5 (rs2) in ID -> stall=1 for exactly 1 cycle, then fwd_ex=4'b1000, and stall_count increases by 1.
REQ-019 Scenario: lw r7 in EX, then beqz r7 in ID -> stall=1 for 2 cycles, then fwd_id=2'b00 (WB path), with EX record valid=0 on both bubble cycles.
REQ-020 Scenario: lw r4 in EX, then sw with rs2=r4 in ID -> mem_wb_mem=1, stall=0 if HAZ_STORE_FWD_EN is defined; otherwise stall=1 for 1 cycle and mem_wb_mem=0.
REQ-021 Scenario: r0 destination, or both EX and MEM producing r9 with the ID instruction reading r9 on rs1 -> no action for r0; fwd_ex=4'b0001 for r9 (EX wins).
REQ-022 Scenario: force 70000 stall cycles -> stall_count=16'hFFFF. Then reset=0 mid-stall -> stall_count=0 and stall=0 next cycle.
